// File: rtl/gf_mul_inv_unit.sv
// ============================================================================
//  Module      : gf_mul_inv_unit
//  Description : Multi-lane GF(2^M) arithmetic unit. Each transaction carries
//                LANES independent operand pairs and one shared operation:
//                field multiplication a*b or field inversion a^-1. Inversion
//                uses the square-and-multiply chain r <- r^2 * a, run M-2
//                times from r = a, followed by a final squaring. That gives
//                a^(2^M - 2), which equals a^-1 for a != 0 and 0 for a = 0.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    M      field width in bits (3..16)
//    POLY   reduction polynomial, M+1 bits, bit M and bit 0 set
//    LANES  operand pairs per transaction
//  Ports
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    in_valid_i   request valid
//    in_ready_o   request accepted when high together with in_valid_i
//    in_op_i      0 = multiply, 1 = invert in_a_i
//    in_a_i       operand A, lane i at [i*M +: M]
//    in_b_i       operand B, ignored for invert
//    out_valid_o  result valid
//    out_ready_i  consumer accepts the result
//    out_data_o   result, same lane packing as the operands
//    out_op_o     operation of the presented result
//    busy_o       a transaction is in flight or awaiting consumption
// ============================================================================
`default_nettype none

module gf_mul_inv_unit #(
    parameter int unsigned   M     = 8,
    parameter logic [M:0]    POLY  = 9'h11B,
    parameter int unsigned   LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_op_i,
    input  logic [LANES*M-1:0] in_a_i,
    input  logic [LANES*M-1:0] in_b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [LANES*M-1:0] out_data_o,
    output logic               out_op_o,
    output logic               busy_o
);

    localparam int unsigned CNT_W = $clog2(M);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IDLE = 3'd1,
        ST_MUL  = 3'd2,
        ST_INV  = 3'd3,
        ST_SQ   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LANES*M-1:0] a_q;
    logic [LANES*M-1:0] b_q;
    logic [LANES*M-1:0] r_q;
    logic [LANES*M-1:0] res_q;
    logic               op_q;
    logic               out_op_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [LANES*M-1:0] mul_d;
    logic [LANES*M-1:0] step_d;
    logic [LANES*M-1:0] sq_d;

    // Carry-less shift-and-add multiply; the shifted multiplicand is reduced
    // by POLY every step so no intermediate ever exceeds M bits.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x,
                                            input logic [M-1:0] y);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = x;
        for (int k = 0; k < int'(M); k++) begin
            if (y[k]) begin
                acc = acc ^ sh;
            end
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY[M-1:0] : {M{1'b0}});
        end
        return acc;
    endfunction

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        logic [M-1:0] a_l;
        logic [M-1:0] b_l;
        logic [M-1:0] r_l;
        logic [M-1:0] sq_l;

        assign a_l = a_q[g*M +: M];
        assign b_l = b_q[g*M +: M];
        assign r_l = r_q[g*M +: M];

        assign sq_l                = gf_mul(r_l, r_l);
        assign mul_d[g*M +: M]     = gf_mul(a_l, b_l);
        assign sq_d[g*M +: M]      = sq_l;
        assign step_d[g*M +: M]    = gf_mul(sq_l, a_l);
    end

    // Handshake/status flags are registered and updated together with the
    // state so they always reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            res_q       <= '0;
            op_q        <= 1'b0;
            out_op_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_RST: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
                ST_IDLE: begin
                    if (in_valid_i) begin
                        a_q        <= in_a_i;
                        b_q        <= in_b_i;
                        op_q       <= in_op_i;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (in_op_i) begin
                            r_q     <= in_a_i;
                            cnt_q   <= CNT_W'(M - 2);
                            state_q <= ST_INV;
                        end else begin
                            state_q <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    res_q       <= mul_d;
                    out_op_q    <= op_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_INV: begin
                    r_q   <= step_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_SQ;
                    end
                end
                ST_SQ: begin
                    res_q       <= sq_d;
                    out_op_q    <= op_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_RST;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = res_q;
    assign out_op_o    = out_op_q;
    assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gf_mul_inv_unit.sv
// ============================================================================
//  Module      : tb_gf_mul_inv_unit
//  Description : Directed bench for gf_mul_inv_unit: AES-field instance
//                (M=8, 4 lanes) and a GF(2^4) instance (POLY=0x13, 1 lane).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf_mul_inv_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // M=8 instance
    logic        in_valid8 = 1'b0, in_op8 = 1'b0, out_ready8 = 1'b1;
    logic [31:0] in_a8 = '0, in_b8 = '0;
    logic        in_ready8, out_valid8, out_op8, busy8;
    logic [31:0] out_data8;

    // M=4 instance
    logic        in_valid4 = 1'b0, in_op4 = 1'b0, out_ready4 = 1'b1;
    logic [3:0]  in_a4 = '0, in_b4 = '0;
    logic        in_ready4, out_valid4, out_op4, busy4;
    logic [3:0]  out_data4;

    gf_mul_inv_unit #(.M(8), .POLY(9'h11B), .LANES(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8), .in_op_i(in_op8),
        .in_a_i(in_a8), .in_b_i(in_b8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .out_data_o(out_data8), .out_op_o(out_op8), .busy_o(busy8)
    );

    gf_mul_inv_unit #(.M(4), .POLY(5'h13), .LANES(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_op_i(in_op4),
        .in_a_i(in_a4), .in_b_i(in_b4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4),
        .out_data_o(out_data4), .out_op_o(out_op4), .busy_o(busy4)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request on the M=8 instance and wait for out_valid.
    // Returns at the negedge of the first DONE cycle; lat counts cycles
    // after the acceptance edge (1 = first cycle after acceptance).
    task automatic txn8(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic o, output int lat,
                        output logic bz1);
        int t;
        t = 0;
        while (!in_ready8 && t < 50) begin @(negedge clk); t++; end
        in_op8 = op; in_a8 = a; in_b8 = b; in_valid8 = 1'b1;
        @(negedge clk);
        bz1 = busy8;
        in_valid8 = 1'b0; in_op8 = ~op; in_a8 = $urandom; in_b8 = $urandom;
        lat = 1;
        while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
        d = out_data8;
        o = out_op8;
    endtask

    task automatic txn4(input logic op, input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] d, output int lat);
        int t;
        t = 0;
        while (!in_ready4 && t < 50) begin @(negedge clk); t++; end
        in_op4 = op; in_a4 = a; in_b4 = b; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0; in_op4 = ~op; in_a4 = 4'($urandom); in_b4 = 4'($urandom);
        lat = 1;
        while (!out_valid4 && lat < 100) begin @(negedge clk); lat++; end
        d = out_data4;
    endtask

    initial begin
        logic [31:0] d, a, invd;
        logic [3:0]  d4;
        logic        o, bz;
        int          lat;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_in_ready",  in_ready8,  1'b0);
        check("rst_out_valid", out_valid8, 1'b0);
        check("rst_busy",      busy8,      1'b0);
        check("rst_out_data",  out_data8,  32'h0);
        check("rst_out_op",    out_op8,    1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready8, 1'b1);

        // ---------------- multiply, 4 lanes ----------------
        out_ready8 = 1'b1;
        txn8(1'b0, 32'h01000257, 32'hA5FF8783, d, o, lat, bz);
        check("mul_data",    d,   32'hA50015C1);
        check("mul_latency", lat, 2);
        check("mul_op",      o,   1'b0);
        @(negedge clk);
        check("mul_valid_one_cycle", out_valid8, 1'b0);
        check("mul_ready_again",     in_ready8,  1'b1);

        // ---------------- invert, 4 lanes ----------------
        txn8(1'b1, 32'hCA000153, 32'h0, d, o, lat, bz);
        check("inv_data",       d,     32'h530001CA);
        check("inv_latency",    lat,   8);
        check("inv_op",         o,     1'b1);
        check("inv_busy_first", bz,    1'b1);
        check("inv_busy_last",  busy8, 1'b1);
        @(negedge clk);
        check("inv_busy_after", busy8, 1'b0);

        // ---------------- backpressure ----------------
        out_ready8 = 1'b0;
        txn8(1'b1, 32'h00000053, 32'h0, d, o, lat, bz);
        check("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin in_valid8 = 1'b1; in_op8 = 1'b0; end
            if (i == 2) in_valid8 = 1'b0;
            check("bp_hold_data",  out_data8,  32'h000000CA);
            check("bp_hold_valid", out_valid8, 1'b1);
            check("bp_no_ready",   in_ready8,  1'b0);
            @(negedge clk);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        check("bp_released_valid", out_valid8, 1'b0);
        check("bp_released_ready", in_ready8,  1'b1);
        @(negedge clk);
        check("bp_stray_not_taken", busy8, 1'b0);

        // ---------------- reset mid-INV ----------------
        txn8(1'b1, 32'h00000053, 32'h0, d, o, lat, bz);  // out_data now 0xCA
        @(negedge clk);                                  // consumed
        a = 32'h00000053;
        in_op8 = 1'b1; in_a8 = a; in_valid8 = 1'b1;
        @(negedge clk);                                  // N+1
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);                       // N+4
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid8, 1'b0);
        check("midrst_busy",      busy8,      1'b0);
        check("midrst_in_ready",  in_ready8,  1'b0);
        check("midrst_out_data",  out_data8,  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", in_ready8, 1'b1);
        txn8(1'b0, 32'h00000057, 32'h00000083, d, o, lat, bz);
        check("midrst_mul_data", d, 32'h000000C1);

        // ---------------- exhaustive inv(a)*a, alternating ops ----------------
        for (int base = 1; base < 256; base += 4) begin
            for (int l = 0; l < 4; l++)
                a[l*8 +: 8] = (base + l > 255) ? 8'h01 : 8'(base + l);
            txn8(1'b1, a, 32'h0, invd, o, lat, bz);
            check("exh_inv_op", o, 1'b1);
            txn8(1'b0, invd, a, d, o, lat, bz);
            check("exh_mul_op", o, 1'b0);
            check("exh_inv_times_a", d, 32'h01010101);
        end

        // ---------------- GF(2^4), POLY 0x13 ----------------
        txn4(1'b1, 4'h2, 4'h0, d4, lat);
        check("m4_inv_data",    d4,  4'h9);
        check("m4_inv_latency", lat, 4);
        txn4(1'b0, 4'h3, 4'h7, d4, lat);
        check("m4_mul_data",    d4,  4'h9);
        check("m4_mul_latency", lat, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
